// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory widths and burst reader state encoding
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry registered stream buffer with occupancy count
// The writer must respect count; there is no upstream ready.
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign m_tdata  = head_q;
  assign m_tvalid = (count_q != 2'd0);
  assign count    = count_q;
  assign pop      = m_tvalid & m_tready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({s_tvalid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = s_tdata;
        else                 tail_d = s_tdata;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = s_tdata;
        end else begin
          head_d = tail_q;
          tail_d = s_tdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - burst read initiator streaming memory words downstream
// Optional MEM_BURST_CHECKSUM_EN adds a running sum of accepted words.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int WORD_W = MEM_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rwn,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MEM_BURST_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              issue;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;

  // Words that will be buffered after this cycle, not counting a new issue.
  assign pop = out_valid & out_ready;
  assign occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  stream_fifo2 #(.W(WORD_W)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (mem_data),
    .s_tvalid (inflight_q),
    .m_tdata  (out_data),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .count    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          addr_d      = base_addr;
          remaining_d = burst_len;
          state_d     = (burst_len == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (remaining_q != '0 && occ < 3'd2) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          if (remaining_q == (ADDR_W + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == 3'd0) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
  end

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == FINISH);
  assign mem_rwn  = issue;
  assign mem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef MEM_BURST_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && go) sum_d = '0;
    else if (pop)              sum_d = sum_q + out_data;
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - randomized scoreboard bench for mem_burst_reader
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [15:0] base_addr;
  logic [16:0] burst_len;
  logic        busy, done, mem_rwn, out_valid, out_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_data, out_data;
`ifdef MEM_BURST_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_burst_reader dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rwn   (mem_rwn),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MEM_BURST_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] exp_q [$];
  logic [15:0] addr_q [$];
  logic [31:0] exp_sum;
  int total = 0, bad = 0;
  int cyc = 0, go_cyc = 0, ready_mode = 0;
  int first_valid, first_rwn, rwn_cnt, pop_cnt, issued, accepted;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: registered read data, one cycle after the strobe.
  initial begin
    logic       pend;
    logic [15:0] pa;
    mem_data = '0;
    forever begin
      @(negedge clk);
      pend = mem_rwn;
      pa   = mem_addr;
      @(posedge clk);
      #1;
      if (pend) mem_data = mem[pa];
    end
  end

  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: checks issued addresses and streamed words against the queues.
  initial begin
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_rwn) begin
          if (addr_q.size() == 0) chk("unexpected_issue", 1, 0);
          else chk("mem_addr", mem_addr, addr_q.pop_front());
          issued++;
          rwn_cnt++;
          if (first_rwn < 0) first_rwn = cyc - go_cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc - go_cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else chk("out_data", out_data, exp_q.pop_front());
          accepted++;
          pop_cnt++;
        end
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
        end
        chk("occupancy_le_3", (issued - accepted) <= 3, 1);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic start_burst(input logic [15:0] b, input logic [16:0] l, input int mode);
    @(posedge clk);
    #1;
    ready_mode  = mode;
    go          = 1'b1;
    base_addr   = b;
    burst_len   = l;
    go_cyc      = cyc;
    first_valid = -1;
    first_rwn   = -1;
    rwn_cnt     = 0;
    pop_cnt     = 0;
    exp_sum     = '0;
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] a;
      a = 16'(int'(b) + i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
      exp_sum += mem[a];
    end
    @(posedge clk);
    #1;
    go        = 1'b0;
    base_addr = 16'($urandom);
    burst_len = 17'($urandom);
  endtask

  task automatic burst(input logic [15:0] b, input logic [16:0] l, input int mode, input bit inject);
    bit seen = 1'b0;
    int rel = 0;
    start_burst(b, l, mode);
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(negedge clk);
      rel = cyc - go_cyc;
      if (rel == 1) chk("busy_cycle1", busy, l != 0);
      if (inject && l != 0 && rel == 2) begin
        go = 1'b1; base_addr = 16'($urandom); burst_len = 17'($urandom_range(1, 9));
      end
      if (inject && rel == 3) go = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 0);
      if (l == 0) chk("done_cycle_len0", rel, 1);
      else if (mode == 0) begin
        chk("done_cycle", rel, int'(l) + 3);
        chk("first_issue_cycle", first_rwn, 1);
        chk("first_valid_cycle", first_valid, 3);
      end
      chk("issue_count", rwn_cnt, l);
      chk("words_left", exp_q.size(), 0);
`ifdef MEM_BURST_CHECKSUM_EN
      chk("checksum", checksum, exp_sum);
`endif
      if (inject) begin
        go = 1'b1; base_addr = 16'($urandom); burst_len = 17'd5;
      end
      @(negedge clk);
      go = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; base_addr = '0; burst_len = '0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 + i;
    mem[16'h0200] = 32'hFFFF_FFFF;
    mem[16'h0201] = 32'h0000_0002;
    issued = 0; accepted = 0; first_valid = -1; first_rwn = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rwn", mem_rwn, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    #1 reset = 1'b0;

    burst(16'h0010, 17'd4, 0, 1'b0);
    burst(16'h0010, 17'd4, 1, 1'b0);
    burst(16'hFFFF, 17'd3, 0, 1'b0);
    burst(16'h0040, 17'd0, 0, 1'b1);
    burst(16'h0100, 17'd6, 2, 1'b1);
    burst(16'h0200, 17'd2, 0, 1'b0);

    // Reset in the middle of a burst.
    start_burst(16'h0300, 17'd8, 0);
    for (int n = 0; n < 100 && pop_cnt < 2; n++) @(negedge clk);
    chk("reset_test_progress", pop_cnt >= 2, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    accepted = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mem_rwn", mem_rwn, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    repeat (6) begin
      @(negedge clk);
      chk("no_stray_after_rst", {out_valid, done, mem_rwn}, 0);
    end
    burst(16'h0010, 17'd4, 0, 1'b0);

    for (int k = 0; k < 15; k++) begin
      logic [15:0] b;
      logic [16:0] l;
      int m;
      b = ($urandom % 2) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      l = 17'($urandom_range(0, 24));
      m = $urandom_range(0, 2);
      burst(b, l, m, (l != 0) && ($urandom % 2 == 1));
    end
    burst(16'h1000, 17'd300, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side initiator for the shared word memory. It owns the memory's test-read port (read address plus read strobe) and consumes its registered read data.
- On a go pulse it reads burst_len consecutive words starting at base_addr.
- It streams the words out on a valid/ready interface to the checker/host side.
- It keeps throughput at one word per cycle while absorbing the memory's one-cycle read latency and downstream backpressure.

Parameters:
- ADDR_W, 16, memory address width (word addressed).
- WORD_W, 32, memory word width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start-burst pulse; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address, latched on accepted go.
- burst_len  input  ADDR_W+1  word count, 0..2^ADDR_W, latched on accepted go.
- busy  output  1  high from the cycle after an accepted go until done.
- done  output  1  one-cycle pulse when the burst completes.
- mem_addr  output  ADDR_W  read address to memory.
- mem_rwn  output  1  read strobe to memory; high only on issue cycles.
- mem_data  input  WORD_W  memory read data, valid the cycle after the strobe.
- out_data  output  WORD_W  streamed word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when valid and ready are both high.

Behaviour:
- Reset (synchronous, active-high) values:
  - busy=0, done=0, mem_rwn=0, mem_addr=0, out_valid=0, out_data=0.
  - Buffer is emptied, in-flight flag is cleared, state is IDLE.
- States:
  - IDLE: go=1 latches base_addr/burst_len. If burst_len=0, go to FINISH; otherwise go to RUN.
  - RUN: issue reads. After the last read has been issued, go to DRAIN.
  - DRAIN: no issues. When the buffer is empty, nothing is in flight and the last word has been accepted, go to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- Issue rule (RUN only): mem_rwn=1 and mem_addr=next address when remaining>0 and (buf_count + inflight - pop_this_cycle) < 2.
  - A 2-entry output buffer plus one in-flight slot gives full rate under continuous out_ready.
- mem_rwn must be 0 on every non-issue cycle. The memory gives read priority over decoder writes, so a stuck strobe blocks writes.
- Capture: a word is written into the buffer on the edge ending the cycle after an issue (mem_data valid then). Order is preserved.
- Latency: go high in cycle 0 → mem_rwn=1 with mem_addr=base_addr in cycle 1 → out_valid=1 with out_data=mem[base_addr] in cycle 3.
- Address arithmetic is mod 2^ADDR_W: base 0xFFFF, length 3 reads 0xFFFF, 0x0000, 0x0001.
- burst_len=2^ADDR_W reads every word once.
- out_valid held with out_ready low: out_data must stay stable. No issue when the buffer plus in-flight slot is full.
- go while busy or in FINISH is ignored and does not corrupt the current burst.
- Reset mid-burst: return to IDLE at once. Memory data returning after reset is discarded. No done pulse.
- done coincides with busy falling: busy=0 in the done cycle.

Optional Feature:
- Macro MEM_BURST_CHECKSUM_EN.
- Defined:
  - Adds output checksum (WORD_W), the mod-2^WORD_W sum of all words accepted downstream in the current burst.
  - Cleared on accepted go; valid and stable from the done cycle until the next accepted go; reset value 0.
- Undefined: no checksum port or logic.

Decomposition:
- Package mem_pkg:
  - MEM_ADDR_W=16, MEM_WORD_W=32.
  - State enum {IDLE, RUN, DRAIN, FINISH}.
  - Shared with the memory and the decoder-side writer.
- Sub-module stream_fifo2: 2-entry valid/ready buffer with count output, used as the output buffer.

Test Plan:
- Preload mem[0x10..0x13]=A0..A3; go, base=0x10, len=4, out_ready=1 → A0..A3 on consecutive cycles 3..6; done in cycle 7; mem_rwn high exactly 4 cycles.
- Same burst with out_ready toggling 1,0,0,1,… → order A0..A3 preserved; out_data stable while stalled; never more than 2 buffered plus 1 in flight.
- base=0xFFFF, len=3 → mem_addr sequence 0xFFFF, 0x0000, 0x0001; data order matches.
- len=0 → no mem_rwn, no out_valid, done one cycle after go; second go during a burst ignored.
- reset asserted mid-burst after 2 words → all outputs 0 next cycle; no stray out_valid/done; new burst afterwards correct.
- With MEM_BURST_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001 at done.
